// File: rtl/comm_align_pkg.sv
// comm_align_pkg: shared definitions for the comm-path delay alignment logic.
// State encoding of the alignment controller and the default training word.
package comm_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CHECK  = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } align_state_e;

  localparam logic [7:0] DEFAULT_PATTERN = 8'hA5;

endpackage

// File: rtl/delay_align_ctrl_run_counter.sv
// run_counter: saturating up-counter with synchronous clear and clock enable.
// tc reports that the count currently equals the supplied terminal value.
module run_counter #(
  parameter int W = 6
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         ce,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] last,
  output logic         tc
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear has priority, increment stops at the terminal value
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {W{1'b0}};
    end else if (inc && (count_q != last)) begin
      count_d = count_q + W'(1'b1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register, frozen while ce is low
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= {W{1'b0}};
    end else if (ce) begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == last);

endmodule

// File: rtl/delay_align_ctrl.sv
// delay_align_ctrl: sweeps the delay-line select, settles, checks the delayed
// data for the training word and locks on a passing setting (or flags fail).
// Optional eye centering is enabled by defining DELAY_ALIGN_MIDPOINT_EN.
module delay_align_ctrl
  import comm_align_pkg::*;
#(
  parameter int               SEL_WIDTH     = 4,
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] PATTERN       = WIDTH'(DEFAULT_PATTERN),
  parameter int               SETTLE_CYCLES = 32,
  parameter int               CHECK_CYCLES  = 16,
  parameter int               MATCH_COUNT   = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ce,
  input  logic                 start,
  input  logic [WIDTH-1:0]     din,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 busy,
  output logic                 locked,
  output logic                 fail
);

  localparam int WIN_MAX = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
  localparam int CW      = $clog2(WIN_MAX) + 1;
  localparam int RW      = $clog2(MATCH_COUNT) + 1;
  localparam logic [SEL_WIDTH-1:0] SEL_ZERO    = {SEL_WIDTH{1'b0}};
  localparam logic [SEL_WIDTH-1:0] SEL_MAX     = {SEL_WIDTH{1'b1}};
  localparam logic [CW-1:0]        SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]        CHECK_LAST  = CW'(CHECK_CYCLES - 1);
  localparam logic [RW-1:0]        RUN_LAST    = RW'(MATCH_COUNT - 1);

  align_state_e         state_q, state_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic                 busy_q, busy_d;
  logic                 locked_q, locked_d;
  logic                 fail_q, fail_d;

  logic          win_clr, win_inc, win_tc;
  logic          run_clr, run_inc, run_tc;
  logic [CW-1:0] win_last;
  logic          match;
  logic          pass;

`ifdef DELAY_ALIGN_MIDPOINT_EN
  logic [SEL_WIDTH-1:0] lo_q, lo_d;
  logic                 in_run_q, in_run_d;
  logic                 final_q, final_d;
  logic [SEL_WIDTH-1:0] lo_eff;

  // Centre of the eye; the extra sum bit keeps lo+hi from wrapping
  function automatic logic [SEL_WIDTH-1:0] mid_sel(input logic [SEL_WIDTH-1:0] a,
                                                   input logic [SEL_WIDTH-1:0] b);
    logic [SEL_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[SEL_WIDTH:1];
  endfunction
`endif

  // One counter serves both the settle wait and the check window
  assign win_last = (state_q == ST_SETTLE) ? SETTLE_LAST : CHECK_LAST;
  assign match    = (din == PATTERN);
  assign pass     = match && run_tc;

  run_counter #(.W(CW)) u_win_cnt (
    .CLK (CLK), .RST (RST), .ce (ce),
    .clr (win_clr), .inc (win_inc), .last (win_last), .tc (win_tc)
  );

  run_counter #(.W(RW)) u_run_cnt (
    .CLK (CLK), .RST (RST), .ce (ce),
    .clr (run_clr), .inc (run_inc), .last (RUN_LAST), .tc (run_tc)
  );

  // Next-state and output decisions of the alignment search
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    locked_d = locked_q;
    fail_d   = fail_q;
    win_clr  = 1'b0;
    win_inc  = 1'b0;
    run_clr  = 1'b0;
    run_inc  = 1'b0;
`ifdef DELAY_ALIGN_MIDPOINT_EN
    lo_d     = lo_q;
    in_run_d = in_run_q;
    final_d  = final_q;
    lo_eff   = in_run_q ? lo_q : sel_q;
`endif
    case (state_q)
      ST_IDLE, ST_LOCKED, ST_FAIL: begin
        win_clr = 1'b1;
        run_clr = 1'b1;
        if (start) begin
          state_d  = ST_SETTLE;
          sel_d    = SEL_ZERO;
          busy_d   = 1'b1;
          locked_d = 1'b0;
          fail_d   = 1'b0;
`ifdef DELAY_ALIGN_MIDPOINT_EN
          lo_d     = SEL_ZERO;
          in_run_d = 1'b0;
          final_d  = 1'b0;
`endif
        end else begin
          state_d = state_q;
        end
      end
      ST_SETTLE: begin
        run_clr = 1'b1;
        if (win_tc) begin
          win_clr = 1'b1;
`ifdef DELAY_ALIGN_MIDPOINT_EN
          if (final_q) begin
            state_d  = ST_LOCKED;
            busy_d   = 1'b0;
            locked_d = 1'b1;
            final_d  = 1'b0;
          end else begin
            state_d = ST_CHECK;
          end
`else
          state_d = ST_CHECK;
`endif
        end else begin
          win_inc = 1'b1;
        end
      end
      ST_CHECK: begin
        if (pass || win_tc) begin
          win_clr = 1'b1;
          run_clr = 1'b1;
`ifdef DELAY_ALIGN_MIDPOINT_EN
          if (pass) begin
            lo_d = lo_eff;
            if (sel_q == SEL_MAX) begin
              sel_d   = mid_sel(lo_eff, sel_q);
              final_d = 1'b1;
            end else begin
              sel_d    = sel_q + SEL_WIDTH'(1'b1);
              in_run_d = 1'b1;
            end
            state_d = ST_SETTLE;
          end else if (in_run_q) begin
            // First failure after a run: the previous setting was the last pass
            sel_d   = mid_sel(lo_q, sel_q - SEL_WIDTH'(1'b1));
            final_d = 1'b1;
            state_d = ST_SETTLE;
          end else if (sel_q == SEL_MAX) begin
            state_d = ST_FAIL;
            sel_d   = SEL_ZERO;
            busy_d  = 1'b0;
            fail_d  = 1'b1;
          end else begin
            sel_d   = sel_q + SEL_WIDTH'(1'b1);
            state_d = ST_SETTLE;
          end
`else
          if (pass) begin
            state_d  = ST_LOCKED;
            busy_d   = 1'b0;
            locked_d = 1'b1;
          end else if (sel_q == SEL_MAX) begin
            state_d = ST_FAIL;
            sel_d   = SEL_ZERO;
            busy_d  = 1'b0;
            fail_d  = 1'b1;
          end else begin
            sel_d   = sel_q + SEL_WIDTH'(1'b1);
            state_d = ST_SETTLE;
          end
`endif
        end else begin
          win_inc = 1'b1;
          if (match) begin
            run_inc = 1'b1;
          end else begin
            run_clr = 1'b1;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        sel_d    = SEL_ZERO;
        busy_d   = 1'b0;
        locked_d = 1'b0;
        fail_d   = 1'b0;
        win_clr  = 1'b1;
        run_clr  = 1'b1;
      end
    endcase
  end

  // State and registered outputs, frozen while ce is low
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      sel_q    <= SEL_ZERO;
      busy_q   <= 1'b0;
      locked_q <= 1'b0;
      fail_q   <= 1'b0;
`ifdef DELAY_ALIGN_MIDPOINT_EN
      lo_q     <= SEL_ZERO;
      in_run_q <= 1'b0;
      final_q  <= 1'b0;
`endif
    end else if (ce) begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      locked_q <= locked_d;
      fail_q   <= fail_d;
`ifdef DELAY_ALIGN_MIDPOINT_EN
      lo_q     <= lo_d;
      in_run_q <= in_run_d;
      final_q  <= final_d;
`endif
    end
  end

  assign sel    = sel_q;
  assign busy   = busy_q;
  assign locked = locked_q;
  assign fail   = fail_q;

endmodule

// File: tb/tb_delay_align_ctrl.sv
// tb_delay_align_ctrl: randomized self-checking bench for delay_align_ctrl.
// The expected outcome of each search (lock setting, fail, ce-cycle cost) is
// derived from the passing set alone; eye centering follows DELAY_ALIGN_MIDPOINT_EN.
module tb_delay_align_ctrl;

  localparam int S    = 32;
  localparam int C    = 16;
  localparam int M    = 4;
  localparam int NSEL = 16;
  localparam int CAND = S + C;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ce = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  din;
  logic [3:0]  sel;
  logic        busy, locked, fail;
  logic [15:0] pass_mask = 16'h0000;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  // Delay line stand-in: training word only at passing settings
  assign din = pass_mask[sel] ? 8'hA5 : 8'h00;

  delay_align_ctrl dut (
    .CLK(CLK), .RST(RST), .ce(ce), .start(start), .din(din),
    .sel(sel), .busy(busy), .locked(locked), .fail(fail)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected result of a full search over passing set m, in ce cycles after start
  function automatic void model(input logic [15:0] m, output bit exp_lock,
                                output int exp_sel, output int exp_n);
    int first;
    int hi;
    first = -1;
    for (int i = NSEL - 1; i >= 0; i--) if (m[i]) first = i;
    if (first < 0) begin
      exp_lock = 1'b0;
      exp_sel  = 0;
      exp_n    = NSEL * CAND;
    end else begin
      exp_lock = 1'b1;
`ifdef DELAY_ALIGN_MIDPOINT_EN
      hi = first;
      while (hi < NSEL - 1 && m[hi + 1]) hi++;
      exp_sel = (first + hi) / 2;
      exp_n   = first * CAND + (hi - first + 1) * (S + M) + ((hi < NSEL - 1) ? CAND : 0) + S;
`else
      hi      = first;
      exp_sel = hi;
      exp_n   = first * CAND + S + M;
`endif
    end
  endfunction

  // Reset, start a search and run it to completion; mode 0: ce high,
  // 1: ce alternating, 2: random ce. poke_at pulses start mid-run (-1 none).
  task automatic run_search(input logic [15:0] m, input int mode, input int poke_at,
                            input string tag, output int cycles, output int ce_edges,
                            output int sel_at_poke);
    logic [3:0] p_sel;
    logic       p_busy, p_locked, p_fail;
    bit         ce_now;
    bit         done;
    int         bad_freeze;
    int         bad_sel;
    bad_freeze  = 0;
    bad_sel     = 0;
    done        = 1'b0;
    sel_at_poke = -1;
    pass_mask   = m;
    RST = 1'b1; ce = 1'b1; start = 1'b0;
    tick(); tick();
    RST = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cycles = 0;
    ce_edges = 0;
    n_cmp++;
    if (busy !== 1'b1 || sel !== 4'd0 || locked !== 1'b0 || fail !== 1'b0) begin
      n_bad++;
      $display("FAIL %s start_response: busy=%b sel=%0d locked=%b fail=%b required busy=1 sel=0 locked=0 fail=0",
               tag, busy, sel, locked, fail);
    end
    while (!done && cycles < 5000) begin
      case (mode)
        0:       ce_now = 1'b1;
        1:       ce_now = ((cycles + 1) % 2 == 0);
        default: ce_now = ($urandom_range(0, 3) != 0);
      endcase
      ce = ce_now;
      if (cycles == poke_at) begin
        start = 1'b1;
        sel_at_poke = int'(sel);
      end else begin
        start = 1'b0;
      end
      p_sel = sel; p_busy = busy; p_locked = locked; p_fail = fail;
      tick();
      cycles++;
      if (ce_now) ce_edges++;
      if (!ce_now && {sel, busy, locked, fail} !== {p_sel, p_busy, p_locked, p_fail}) bad_freeze++;
      if (sel !== p_sel) begin
`ifdef DELAY_ALIGN_MIDPOINT_EN
        if (!p_busy) bad_sel++;
`else
        if (!p_busy || !((int'(sel) == int'(p_sel) + 1) || (fail && sel == 4'd0))) bad_sel++;
`endif
      end
      if (locked || fail) done = 1'b1;
    end
    ce = 1'b1;
    start = 1'b0;
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL %s timeout: no locked/fail after %0d cycles, required completion", tag, cycles);
    end
    n_cmp++;
    if (bad_freeze !== 0) begin
      n_bad++;
      $display("FAIL %s ce_freeze: %0d output changes with ce low, required 0", tag, bad_freeze);
    end
    n_cmp++;
    if (bad_sel !== 0) begin
      n_bad++;
      $display("FAIL %s sel_steps: %0d illegal sel changes, required 0", tag, bad_sel);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; ce = 1'b1; start = 1'b0; pass_mask = 16'h0000;
    repeat (3) tick();
    RST = 1'b0;
    n_cmp++;
    if (sel !== 4'd0) begin n_bad++; $display("FAIL reset_sel: got %0d required 0", sel); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_cmp++;
    if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b required 0", locked); end
    n_cmp++;
    if (fail !== 1'b0) begin n_bad++; $display("FAIL reset_fail: got %b required 0", fail); end
    repeat (10) tick();
    n_cmp++;
    if ({sel, busy, locked, fail} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_hold: sel=%0d busy=%b locked=%b fail=%b required all 0", sel, busy, locked, fail);
    end
  endtask

  // Runs a ce-high search and checks outcome and exact cycle cost
  task automatic test_search(input logic [15:0] m, input string tag);
    int cyc, cen, sp, es, en;
    bit el;
    model(m, el, es, en);
    run_search(m, 0, -1, tag, cyc, cen, sp);
    n_cmp++;
    if (locked !== el || fail !== !el) begin
      n_bad++;
      $display("FAIL %s outcome: locked=%b fail=%b required locked=%b fail=%b", tag, locked, fail, el, !el);
    end
    n_cmp++;
    if (int'(sel) != es) begin n_bad++; $display("FAIL %s final_sel: got %0d required %0d", tag, sel, es); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL %s final_busy: got %b required 0", tag, busy); end
    n_cmp++;
    if (cyc != en) begin n_bad++; $display("FAIL %s cycles: got %0d required %0d", tag, cyc, en); end
  endtask

  task automatic test_first_pass();
    test_search(16'h00E0, "first_pass");
  endtask

  task automatic test_midpoint();
    test_search(16'h03E0, "mid_5_9");
    test_search(16'hE000, "mid_13_15");
  endtask

  task automatic test_no_pass();
    test_search(16'h0000, "no_pass");
    n_cmp++;
    if (fail !== 1'b1 || sel !== 4'd0) begin
      n_bad++;
      $display("FAIL no_pass_fixed: fail=%b sel=%0d required fail=1 sel=0", fail, sel);
    end
  endtask

  task automatic test_start_ignored();
    int cyc, cen, sp, es, en;
    bit el;
    model(16'h00E0, el, es, en);
    run_search(16'h00E0, 0, 3 * CAND + S + 5, "start_busy", cyc, cen, sp);
    n_cmp++;
    if (sp != 3) begin n_bad++; $display("FAIL start_busy_poke_sel: got %0d required 3", sp); end
    n_cmp++;
    if (locked !== 1'b1 || int'(sel) != es || cyc != en) begin
      n_bad++;
      $display("FAIL start_busy_result: locked=%b sel=%0d cycles=%0d required locked=1 sel=%0d cycles=%0d",
               locked, sel, cyc, es, en);
    end
  endtask

  task automatic test_reset_mid();
    pass_mask = 16'h00E0;
    RST = 1'b1; ce = 1'b1; start = 1'b0;
    tick();
    RST = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2 * CAND + 10) tick();
    n_cmp++;
    if (sel !== 4'd2 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_pre: sel=%0d busy=%b required sel=2 busy=1", sel, busy);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    n_cmp++;
    if ({sel, busy, locked, fail} !== 7'b0) begin
      n_bad++;
      $display("FAIL rst_mid_post: sel=%0d busy=%b locked=%b fail=%b required all 0", sel, busy, locked, fail);
    end
    repeat (S + C) tick();
    n_cmp++;
    if ({sel, busy, locked, fail} !== 7'b0) begin
      n_bad++;
      $display("FAIL rst_mid_idle: sel=%0d busy=%b locked=%b fail=%b required all 0", sel, busy, locked, fail);
    end
  endtask

  task automatic test_restart_locked();
    int cyc, cen, sp;
    run_search(16'h0020, 0, -1, "restart", cyc, cen, sp);
    n_cmp++;
    if (locked !== 1'b1) begin n_bad++; $display("FAIL restart_pre_lock: got %b required 1", locked); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (locked !== 1'b0 || busy !== 1'b1 || sel !== 4'd0) begin
      n_bad++;
      $display("FAIL restart_response: locked=%b busy=%b sel=%0d required locked=0 busy=1 sel=0", locked, busy, sel);
    end
  endtask

  task automatic test_ce_toggle();
    int cyc, cen, sp, es, en;
    bit el;
    model(16'h00E0, el, es, en);
    run_search(16'h00E0, 1, -1, "ce_toggle", cyc, cen, sp);
    n_cmp++;
    if (locked !== 1'b1 || int'(sel) != es) begin
      n_bad++;
      $display("FAIL ce_toggle_lock: locked=%b sel=%0d required locked=1 sel=%0d", locked, sel, es);
    end
    n_cmp++;
    if (cyc != 2 * en) begin n_bad++; $display("FAIL ce_toggle_cycles: got %0d required %0d", cyc, 2 * en); end
  endtask

  task automatic test_random();
    int cyc, cen, sp, es, en, lo, len, kind;
    bit el;
    logic [15:0] m;
    for (int it = 0; it < 6; it++) begin
      kind = $urandom_range(0, 3);
      m = 16'h0000;
      if (kind == 1) begin
        lo  = $urandom_range(0, 15);
        len = $urandom_range(1, 16 - lo);
        for (int b = lo; b < lo + len; b++) m[b] = 1'b1;
      end else if (kind != 0) begin
        m = 16'($urandom & $urandom);
      end
      model(m, el, es, en);
      run_search(m, 2, -1, "random", cyc, cen, sp);
      n_cmp++;
      if (locked !== el || fail !== !el || int'(sel) != es) begin
        n_bad++;
        $display("FAIL random_result mask=%h: locked=%b fail=%b sel=%0d required locked=%b fail=%b sel=%0d",
                 m, locked, fail, sel, el, !el, es);
      end
      n_cmp++;
      if (cen != en) begin
        n_bad++;
        $display("FAIL random_ce_cycles mask=%h: got %0d required %0d", m, cen, en);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_pass();
    test_midpoint();
    test_no_pass();
    test_start_ignored();
    test_reset_mid();
    test_restart_locked();
    test_ce_toggle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/delay_align_ctrl.md
# delay_align_ctrl

Training-time alignment controller driving the `sel` input of the comm-path variable delay line and consuming that line's delayed output. On `start` it sweeps every delay setting, waits for the pipeline to settle, and checks the delayed data for a fixed training pattern. It then locks `sel` on a passing setting, or flags failure if none passes. It sits beside the delay line in the receive path, between the link deserializer output and the framing logic.

## Interface
- `sel_width`, 4: width of `sel`; candidate settings are 0 … 2^sel_width−1.
- `width`, 8: data width of `din`.
- `pattern`, 8'hA5: training word expected on `din` when aligned.
- `settle_cycles`, 32: `ce` cycles to wait after any `sel` change; must be at least the delay line's maximum depth plus 2.
- `check_cycles`, 16: `ce` cycles in one candidate's check window.
- `match_count`, 4: consecutive matching `ce` samples needed to pass; must be ≤ `check_cycles`.
- `CLK`  in  1  system clock; all logic on rising edge.
- `RST`  in  1  synchronous reset, active-high.
- `ce`  in  1  clock enable shared with the delay line; all state, counters and samples advance only when high.
- `start`  in  1  single-cycle request to (re)start alignment.
- `din`  in  width  delayed data from the delay line output.
- `sel`  out  sel_width  registered delay select to the delay line.
- `busy`  out  1  search in progress.
- `locked`  out  1  alignment achieved; `sel` is final.
- `fail`  out  1  no setting passed.

## Operation
- Reset values: `sel`=0, `busy`=0, `locked`=0, `fail`=0, state IDLE, all counters 0.
- States: IDLE, SETTLE, CHECK, LOCKED, FAIL.
- IDLE/LOCKED/FAIL + `start`&`ce` → SETTLE.
  - On this transition: `sel`=0, `busy`=1, `locked`=0, `fail`=0, counters cleared.
- SETTLE: count `settle_cycles` `ce` cycles, then → CHECK. `din` is ignored.
- CHECK: each `ce` cycle, compare `din`==`pattern`.
  - A match increments the run counter; a mismatch clears it.
  - Run reaching `match_count` → candidate passes.
  - Window reaching `check_cycles` without a pass → candidate fails.
- Candidate fails, `sel`<max → `sel`+1, → SETTLE.
- Candidate fails, `sel`=max → FAIL (`busy`=0, `fail`=1, `sel`=0).
- Pass handling depends on the Configuration macro.
- `start` while `busy` is ignored.
- `RST` mid-search returns everything to reset values immediately.
- `ce` low freezes state, counters and outputs; `start` is ignored while `ce` is low.

## Timing
- `busy` rises the cycle after the `start`&`ce` sample.
- Each candidate costs `settle_cycles` + up to `check_cycles` `ce` cycles. With `ce` high, the worst case is 2^sel_width × (settle_cycles + check_cycles) cycles.
- `locked`/`fail` assert, and `busy` deasserts, in the same cycle, one cycle after the deciding `ce` sample.
- `sel` changes only on state transitions. It is stable throughout SETTLE and CHECK.

## Configuration
- `DELAY_ALIGN_MIDPOINT_EN` undefined:
  - The first passing candidate → LOCKED with that `sel`.
- `DELAY_ALIGN_MIDPOINT_EN` defined: eye centering.
  - Record `lo` = the first passing `sel`.
  - Keep scanning while candidates pass. `hi` = the last consecutive pass, ending at the first failure or at max.
  - Set `sel` = (`lo`+`hi`)>>1, using a sel_width+1-bit sum.
  - Then SETTLE once more → LOCKED, with no recheck.
  - With no pass anywhere → FAIL as above.
  - Passes after the first contiguous run are ignored.

## Structure
- Shared package `comm_align_pkg`: state encoding constants (IDLE=0 … FAIL=4) and the default `pattern`.
- Sub-module `run_counter`: a saturating counter with clear, increment and `ce` inputs and a terminal-count output. It is instantiated for both the settle/window counter and the match-run counter.

## Test plan
Common setup: defaults throughout. The bench model drives `din`=8'hA5 only when `sel` is in the listed passing set, otherwise 8'h00.
- Reset: assert `RST` for 3 cycles → `sel`=0, `busy`=0, `locked`=0, `fail`=0; hold for 10 cycles with `start` low → outputs unchanged.
- First-pass lock (macro off), passing set {5,6,7}, pulse `start` → `busy`=1 next cycle; `locked`=1 with `sel`=5 after 6 candidates; `busy`=0.
- Midpoint (macro on), passing set {5…9} → `locked`=1, `sel`=7. Passing set {13,14,15} → `sel`=14, with no wrap past 15.
- No pass, empty passing set → `fail`=1, `sel`=0 after all 16 candidates = 768 cycles with `ce` high.
- Interference:
  - `start` pulsed again during CHECK of `sel`=3 → ignored.
  - `RST` during SETTLE of `sel`=2 → reset values next cycle.
  - `start` while `locked`=1 → `locked`=0 and the search restarts at `sel`=0.
- Clock enable: `ce` toggled 1-0-1-0 during the full run of the first-pass case → identical outputs, lock at `sel`=5, total elapsed cycles doubled.
